// File: rtl/ram_latency_responder_pkg.sv
// Shared types for the latency-modelling RAM responder: bus word, RAM status code
// and the debug encoding of the responder FSM.
package ram_latency_responder_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Encoding of the responder FSM as seen on its debug output.
    localparam logic [1:0] FSM_IDLE  = 2'd0;
    localparam logic [1:0] FSM_COUNT = 2'd1;
    localparam logic [1:0] FSM_DONE  = 2'd2;

endpackage

// File: rtl/ram_latency_responder_if.sv
// Single-port RAM bus between the arbiter (master) and the RAM responder (slave).
// Handshake: ramREN/ramWEN are held with a stable address until ramstate reads ACCESS for one cycle.
interface ram_latency_responder_if;
    import ram_latency_responder_pkg::*;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );

endinterface

// File: rtl/ram_latency_responder_word_array.sv
// Word storage behind the responder: synchronous write, combinational read, contents not reset.
module ram_word_array
    import ram_latency_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             wen,
    input  logic [IDX_W-1:0] widx,
    input  word_t            wdata,
    input  logic [IDX_W-1:0] ridx,
    output word_t            rdata
);

    word_t mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (wen) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/ram_latency_responder.sv
// RAM responder that answers each held request with LAT BUSY cycles and one ACCESS cycle,
// restarting when the requested address/direction changes and dropping aborted requests.
module ram_latency_responder
    import ram_latency_responder_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024
) (
    input  logic                   CLK,
    input  logic                   nRST,
    ram_latency_responder_if.slave bus,
    output logic [1:0]             fsm_state
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam word_t      DEPTH_W  = word_t'(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = FSM_IDLE,
        COUNT = FSM_COUNT,
        DONE  = FSM_DONE
    } state_t;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       lat_wen, lat_wen_next;
    word_t      lat_addr, lat_addr_next;
    word_t      lat_store, lat_store_next;
    word_t      ramload_q;
    logic       load_en;

    logic       req;
    logic       illegal;
    logic       same_req;
    ramstate_t  ramstate_c;

    logic             mem_wen;
    logic [IDX_W-1:0] mem_widx;
    logic [IDX_W-1:0] mem_ridx;
    word_t            mem_rdata;

    assign req      = bus.ramREN | bus.ramWEN;
    assign illegal  = (bus.ramREN & bus.ramWEN)
                    | (bus.ramaddr[1:0] != 2'b00)
                    | ({2'b00, bus.ramaddr[31:2]} >= DEPTH_W);
    assign same_req = (bus.ramWEN == lat_wen) && (bus.ramaddr == lat_addr);

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        lat_wen_next   = lat_wen;
        lat_addr_next  = lat_addr;
        lat_store_next = lat_store;
        load_en        = 1'b0;
        case (state)
            IDLE: begin
                if (req && !illegal) begin
                    lat_wen_next   = bus.ramWEN;
                    lat_addr_next  = bus.ramaddr;
                    lat_store_next = bus.ramstore;
                    if (LAT == 1) begin
                        state_next = DONE;
                        load_en    = !bus.ramWEN;
                    end else begin
                        cnt_next   = CNT_LOAD;
                        state_next = COUNT;
                    end
                end
            end
            COUNT: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (!illegal) begin
                    if (!same_req) begin
                        // The arbiter switched target mid-wait: serve the new request from scratch.
                        lat_wen_next   = bus.ramWEN;
                        lat_addr_next  = bus.ramaddr;
                        lat_store_next = bus.ramstore;
                        cnt_next       = CNT_LOAD;
                    end else begin
                        if (lat_wen) begin
                            lat_store_next = bus.ramstore;
                        end
                        if (cnt == 4'd1) begin
                            state_next = DONE;
                            load_en    = !lat_wen;
                        end else begin
                            cnt_next = cnt - 4'd1;
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        ramstate_c = FREE;
        if (req && illegal) begin
            ramstate_c = ERROR;
        end else begin
            case (state)
                IDLE:    ramstate_c = req ? BUSY : FREE;
                COUNT:   ramstate_c = BUSY;
                DONE:    ramstate_c = ACCESS;
                default: ramstate_c = FREE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_wen   <= 1'b0;
            lat_addr  <= '0;
            lat_store <= '0;
            ramload_q <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            lat_wen   <= lat_wen_next;
            lat_addr  <= lat_addr_next;
            lat_store <= lat_store_next;
            if (load_en) begin
                ramload_q <= mem_rdata;
            end
        end
    end

    // Commit happens on the edge leaving DONE; an async reset in DONE clears state first, so no write.
    assign mem_wen  = (state == DONE) && lat_wen;
    assign mem_widx = lat_addr[IDX_W+1:2];
    assign mem_ridx = (state == IDLE) ? bus.ramaddr[IDX_W+1:2] : lat_addr[IDX_W+1:2];

    ram_word_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .CLK   (CLK),
        .wen   (mem_wen),
        .widx  (mem_widx),
        .wdata (lat_store),
        .ridx  (mem_ridx),
        .rdata (mem_rdata)
    );

    assign bus.ramload  = ramload_q;
    assign bus.ramstate = ramstate_c;
    assign fsm_state    = state;

endmodule

// File: tb/tb_ram_latency_responder.sv
// Bench for the RAM responder: a LAT=2/DEPTH=1024 and a LAT=1/DEPTH=64 instance share one stimulus
// path selected by sel, checked against a transaction-level memory model.
module tb_ram_latency_responder;
    import ram_latency_responder_pkg::*;

    localparam int DEPTH2 = 1024;
    localparam int DEPTH1 = 64;

    logic CLK;
    logic nRST;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    ram_latency_responder_if bus2();
    ram_latency_responder_if bus1();
    logic [1:0] fsm2;
    logic [1:0] fsm1;

    ram_latency_responder #(.LAT(2), .DEPTH(DEPTH2)) dut2 (
        .CLK(CLK), .nRST(nRST), .bus(bus2), .fsm_state(fsm2)
    );
    ram_latency_responder #(.LAT(1), .DEPTH(DEPTH1)) dut1 (
        .CLK(CLK), .nRST(nRST), .bus(bus1), .fsm_state(fsm1)
    );

    logic  sel;
    logic  ren;
    logic  wen;
    word_t addr;
    word_t store;

    assign bus2.ramREN   = ren & !sel;
    assign bus2.ramWEN   = wen & !sel;
    assign bus2.ramaddr  = addr;
    assign bus2.ramstore = store;
    assign bus1.ramREN   = ren & sel;
    assign bus1.ramWEN   = wen & sel;
    assign bus1.ramaddr  = addr;
    assign bus1.ramstore = store;

    ramstate_t  st;
    word_t      load;
    logic [1:0] fsm;
    assign st   = sel ? bus1.ramstate : bus2.ramstate;
    assign load = sel ? bus1.ramload  : bus2.ramload;
    assign fsm  = sel ? fsm1 : fsm2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: word-indexed memories and the last read value of each instance.
    word_t mem2 [int];
    word_t mem1 [int];
    word_t rl2;
    word_t rl1;
    logic [1:0] exp_q [$];

    function automatic int lat_of(input logic s);
        return s ? 1 : 2;
    endfunction

    task automatic ref_access(input logic s, input logic w, input word_t a, input word_t d,
                              output word_t exp_ld);
        int idx;
        idx = int'(a >> 2);
        if (s) begin
            if (w) mem1[idx] = d;
            else   rl1 = mem1[idx];
            exp_ld = rl1;
        end else begin
            if (w) mem2[idx] = d;
            else   rl2 = mem2[idx];
            exp_ld = rl2;
        end
    endtask

    // Holds one request until a non-BUSY status, then releases it; starts and ends just after a rising edge.
    task automatic run_txn(input logic w, input word_t a, input word_t d,
                           output int busy, output ramstate_t last, output word_t ld);
        busy  = 0;
        last  = FREE;
        ld    = '0;
        ren   = !w;
        wen   = w;
        addr  = a;
        store = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            last = st;
            ld   = load;
            @(posedge CLK); #1;
            if (last != BUSY) break;
            busy++;
        end
        ren = 1'b0;
        wen = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; store = '0;
        nRST = 1'b0;
        rl1 = '0; rl2 = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_tests++;
        if (bus2.ramstate !== FREE || bus1.ramstate !== FREE) begin
            n_fail++; $display("FAIL reset_in_reset_state: got %0d/%0d want %0d", bus2.ramstate, bus1.ramstate, FREE);
        end
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            n_tests++;
            if (bus2.ramstate !== FREE || bus1.ramstate !== FREE) begin
                n_fail++; $display("FAIL reset_state: got %0d/%0d want %0d", bus2.ramstate, bus1.ramstate, FREE);
            end
            n_tests++;
            if (bus2.ramload !== 32'h0 || bus1.ramload !== 32'h0) begin
                n_fail++; $display("FAIL reset_load: got %h/%h want 0", bus2.ramload, bus1.ramload);
            end
            n_tests++;
            if (fsm2 !== FSM_IDLE || fsm1 !== FSM_IDLE) begin
                n_fail++; $display("FAIL reset_fsm: got %0d/%0d want %0d", fsm2, fsm1, FSM_IDLE);
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_write_read();
        int busy; ramstate_t last; word_t ld; word_t exp_ld;
        sel = 1'b0;
        run_txn(1'b1, 32'h40, 32'hDEADBEEF, busy, last, ld);
        ref_access(sel, 1'b1, 32'h40, 32'hDEADBEEF, exp_ld);
        n_tests++;
        if (busy !== 2 || last !== ACCESS) begin
            n_fail++; $display("FAIL wr_latency: got busy=%0d end=%0d want busy=2 end=%0d", busy, last, ACCESS);
        end
        n_tests++;
        if (ld !== exp_ld) begin
            n_fail++; $display("FAIL wr_load_hold: got %h want %h", ld, exp_ld);
        end
        run_txn(1'b0, 32'h40, $urandom, busy, last, ld);
        ref_access(sel, 1'b0, 32'h40, '0, exp_ld);
        n_tests++;
        if (busy !== 2 || last !== ACCESS) begin
            n_fail++; $display("FAIL rd_latency: got busy=%0d end=%0d want busy=2 end=%0d", busy, last, ACCESS);
        end
        n_tests++;
        if (ld !== exp_ld) begin
            n_fail++; $display("FAIL rd_data: got %h want %h", ld, exp_ld);
        end
    endtask

    task automatic test_restart();
        int busy; ramstate_t last; word_t ld; word_t exp_ld; word_t v0; word_t v1;
        logic [1:0] want;
        sel = 1'b0;
        v0 = $urandom; v1 = ~v0;
        run_txn(1'b1, 32'h100, v0, busy, last, ld);
        ref_access(sel, 1'b1, 32'h100, v0, exp_ld);
        run_txn(1'b1, 32'h104, v1, busy, last, ld);
        ref_access(sel, 1'b1, 32'h104, v1, exp_ld);
        ref_access(sel, 1'b0, 32'h104, '0, exp_ld);
        exp_q.delete();
        exp_q.push_back(BUSY); exp_q.push_back(BUSY); exp_q.push_back(BUSY); exp_q.push_back(ACCESS);
        ren = 1'b1; wen = 1'b0; addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            want = exp_q.pop_front();
            n_tests++;
            if (st !== want) begin
                n_fail++; $display("FAIL restart_state[%0d]: got %0d want %0d", i, st, want);
            end
            if (i == 3) begin
                n_tests++;
                if (load !== exp_ld) begin
                    n_fail++; $display("FAIL restart_data: got %h want %h", load, exp_ld);
                end
            end
            @(posedge CLK); #1;
            if (i == 0) addr = 32'h104;
        end
        ren = 1'b0;
    endtask

    task automatic test_store_update();
        int busy; ramstate_t last; word_t ld; word_t exp_ld; word_t va; word_t vb;
        logic [1:0] want;
        sel = 1'b0;
        va = $urandom; vb = va ^ 32'h5A5A_A5A5;
        exp_q.delete();
        exp_q.push_back(BUSY); exp_q.push_back(BUSY); exp_q.push_back(ACCESS);
        ren = 1'b0; wen = 1'b1; addr = 32'h80; store = va;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            want = exp_q.pop_front();
            n_tests++;
            if (st !== want) begin
                n_fail++; $display("FAIL store_update_state[%0d]: got %0d want %0d", i, st, want);
            end
            @(posedge CLK); #1;
            if (i == 0) store = vb;
        end
        wen = 1'b0;
        ref_access(sel, 1'b1, 32'h80, vb, exp_ld);
        run_txn(1'b0, 32'h80, '0, busy, last, ld);
        ref_access(sel, 1'b0, 32'h80, '0, exp_ld);
        n_tests++;
        if (last !== ACCESS || ld !== exp_ld) begin
            n_fail++; $display("FAIL store_update_data: got end=%0d data=%h want end=%0d data=%h", last, ld, ACCESS, exp_ld);
        end
    endtask

    task automatic test_illegal();
        int busy; ramstate_t last; word_t ld; word_t exp_ld;
        logic  p_sel [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic  p_ren [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic  p_wen [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        word_t p_addr[5] = '{32'h40, 32'h42, 32'h1000, 32'h100, 32'h0E};
        logic  c_sel [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        word_t c_addr[6] = '{32'h40, 32'h0, 32'hC, 32'h0, 32'hFFC, 32'hFC};
        word_t exp_keep;
        // Known contents at the words an illegal request could alias onto.
        sel = 1'b0;
        run_txn(1'b1, 32'h0, $urandom, busy, last, ld);
        ref_access(sel, 1'b1, 32'h0, bus2.ramstore, exp_ld);
        run_txn(1'b1, 32'hFFC, 32'hA0A0_0FFC, busy, last, ld);
        ref_access(sel, 1'b1, 32'hFFC, 32'hA0A0_0FFC, exp_ld);
        sel = 1'b1;
        run_txn(1'b1, 32'h0, 32'h1111_0000, busy, last, ld);
        ref_access(sel, 1'b1, 32'h0, 32'h1111_0000, exp_ld);
        run_txn(1'b1, 32'hC, 32'h1111_000C, busy, last, ld);
        ref_access(sel, 1'b1, 32'hC, 32'h1111_000C, exp_ld);
        run_txn(1'b1, 32'hFC, 32'h1111_00FC, busy, last, ld);
        ref_access(sel, 1'b1, 32'hFC, 32'h1111_00FC, exp_ld);
        n_tests++;
        if (busy !== 1 || last !== ACCESS) begin
            n_fail++; $display("FAIL top_word_lat1: got busy=%0d end=%0d want busy=1 end=%0d", busy, last, ACCESS);
        end
        for (int p = 0; p < 5; p++) begin
            sel = p_sel[p]; ren = p_ren[p]; wen = p_wen[p]; addr = p_addr[p]; store = $urandom;
            exp_keep = sel ? rl1 : rl2;
            for (int c = 0; c < 2; c++) begin
                @(negedge CLK);
                n_tests++;
                if (st !== ERROR) begin
                    n_fail++; $display("FAIL illegal_state[%0d]: got %0d want %0d", p, st, ERROR);
                end
                n_tests++;
                if (fsm !== FSM_IDLE) begin
                    n_fail++; $display("FAIL illegal_fsm[%0d]: got %0d want %0d", p, fsm, FSM_IDLE);
                end
                n_tests++;
                if (load !== exp_keep) begin
                    n_fail++; $display("FAIL illegal_load[%0d]: got %h want %h", p, load, exp_keep);
                end
                @(posedge CLK); #1;
            end
            ren = 1'b0; wen = 1'b0;
            @(posedge CLK); #1;
        end
        for (int k = 0; k < 6; k++) begin
            sel = c_sel[k];
            run_txn(1'b0, c_addr[k], '0, busy, last, ld);
            ref_access(sel, 1'b0, c_addr[k], '0, exp_ld);
            n_tests++;
            if (busy !== lat_of(sel) || last !== ACCESS || ld !== exp_ld) begin
                n_fail++; $display("FAIL illegal_readback[%0d]: got busy=%0d end=%0d data=%h want busy=%0d end=%0d data=%h",
                                   k, busy, last, ld, lat_of(sel), ACCESS, exp_ld);
            end
        end
    endtask

    task automatic test_abort();
        int busy; ramstate_t last; word_t ld; word_t exp_ld; word_t v_old;
        sel = 1'b0;
        v_old = $urandom;
        run_txn(1'b1, 32'h8, v_old, busy, last, ld);
        ref_access(sel, 1'b1, 32'h8, v_old, exp_ld);
        ren = 1'b0; wen = 1'b1; addr = 32'h8; store = 32'h11;
        @(negedge CLK);
        n_tests++;
        if (st !== BUSY) begin
            n_fail++; $display("FAIL abort_first: got %0d want %0d", st, BUSY);
        end
        @(posedge CLK); #1;
        wen = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        n_tests++;
        if (st !== FREE || fsm !== FSM_IDLE) begin
            n_fail++; $display("FAIL abort_idle: got state=%0d fsm=%0d want state=%0d fsm=%0d", st, fsm, FREE, FSM_IDLE);
        end
        repeat (3) @(posedge CLK);
        #1;
        run_txn(1'b0, 32'h8, '0, busy, last, ld);
        ref_access(sel, 1'b0, 32'h8, '0, exp_ld);
        n_tests++;
        if (last !== ACCESS || ld !== exp_ld) begin
            n_fail++; $display("FAIL abort_no_write: got end=%0d data=%h want end=%0d data=%h", last, ld, ACCESS, exp_ld);
        end
    endtask

    task automatic test_back_to_back();
        word_t exp_ld; word_t a; int lat; logic [1:0] want;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            lat = lat_of(sel);
            a = sel ? 32'hFC : 32'h40;
            ref_access(sel, 1'b0, a, '0, exp_ld);
            exp_q.delete();
            for (int k = 0; k < 2 * (lat + 1); k++) begin
                exp_q.push_back((k % (lat + 1) == lat) ? ACCESS : BUSY);
            end
            ren = 1'b1; wen = 1'b0; addr = a;
            for (int k = 0; k < 2 * (lat + 1); k++) begin
                @(negedge CLK);
                want = exp_q.pop_front();
                n_tests++;
                if (st !== want) begin
                    n_fail++; $display("FAIL b2b_state[lat%0d,%0d]: got %0d want %0d", lat, k, st, want);
                end
                if (want == ACCESS) begin
                    n_tests++;
                    if (load !== exp_ld) begin
                        n_fail++; $display("FAIL b2b_data[lat%0d,%0d]: got %h want %h", lat, k, load, exp_ld);
                    end
                end
                @(posedge CLK); #1;
            end
            ren = 1'b0;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid();
        int busy; ramstate_t last; word_t ld; word_t exp_ld; word_t v0; word_t v1;
        sel = 1'b0;
        v0 = $urandom | 32'h1;
        v1 = ~v0;
        run_txn(1'b1, 32'h20, v0, busy, last, ld);
        ref_access(sel, 1'b1, 32'h20, v0, exp_ld);
        run_txn(1'b0, 32'h20, '0, busy, last, ld);
        ref_access(sel, 1'b0, 32'h20, '0, exp_ld);
        ren = 1'b0; wen = 1'b1; addr = 32'h20; store = v1;
        @(negedge CLK); @(posedge CLK); #1;
        @(negedge CLK); @(posedge CLK); #1;
        @(negedge CLK);
        n_tests++;
        if (st !== ACCESS) begin
            n_fail++; $display("FAIL rstmid_in_done: got %0d want %0d", st, ACCESS);
        end
        nRST = 1'b0; wen = 1'b0;
        rl1 = '0; rl2 = '0;
        #1;
        n_tests++;
        if (st !== FREE || load !== 32'h0 || fsm !== FSM_IDLE) begin
            n_fail++; $display("FAIL rstmid_cleared: got state=%0d load=%h fsm=%0d want state=%0d load=0 fsm=%0d",
                               st, load, fsm, FREE, FSM_IDLE);
        end
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
        run_txn(1'b0, 32'h20, '0, busy, last, ld);
        ref_access(sel, 1'b0, 32'h20, '0, exp_ld);
        n_tests++;
        if (busy !== 2 || last !== ACCESS || ld !== exp_ld) begin
            n_fail++; $display("FAIL rstmid_no_write: got busy=%0d end=%0d data=%h want busy=2 end=%0d data=%h",
                               busy, last, ld, ACCESS, exp_ld);
        end
        sel = 1'b1;
        run_txn(1'b0, 32'hFC, '0, busy, last, ld);
        ref_access(sel, 1'b0, 32'hFC, '0, exp_ld);
        n_tests++;
        if (busy !== 1 || last !== ACCESS || ld !== exp_ld) begin
            n_fail++; $display("FAIL lat1_read: got busy=%0d end=%0d data=%h want busy=1 end=%0d data=%h",
                               busy, last, ld, ACCESS, exp_ld);
        end
    endtask

    task automatic test_random();
        int busy; ramstate_t last; word_t ld; word_t exp_ld; word_t a; word_t d;
        int pool2 [8]; int pool1 [8];
        logic s; logic w;
        pool2[0] = 0; pool2[1] = DEPTH2 - 1;
        pool1[0] = 0; pool1[1] = DEPTH1 - 1;
        for (int i = 2; i < 8; i++) begin
            pool2[i] = $urandom_range(1, DEPTH2 - 2);
            pool1[i] = $urandom_range(1, DEPTH1 - 2);
        end
        for (int i = 0; i < 16; i++) begin
            sel = (i >= 8);
            a = sel ? word_t'(pool1[i % 8]) << 2 : word_t'(pool2[i % 8]) << 2;
            d = $urandom;
            run_txn(1'b1, a, d, busy, last, ld);
            ref_access(sel, 1'b1, a, d, exp_ld);
        end
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            sel = s;
            a = s ? word_t'(pool1[$urandom_range(0, 7)]) << 2 : word_t'(pool2[$urandom_range(0, 7)]) << 2;
            d = $urandom;
            run_txn(w, a, d, busy, last, ld);
            ref_access(s, w, a, d, exp_ld);
            n_tests++;
            if (busy !== lat_of(s) || last !== ACCESS || ld !== exp_ld) begin
                n_fail++; $display("FAIL random[%0d] sel=%0d w=%0d a=%h: got busy=%0d end=%0d data=%h want busy=%0d end=%0d data=%h",
                                   i, s, w, a, busy, last, ld, lat_of(s), ACCESS, exp_ld);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_restart();
        test_store_update();
        test_illegal();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout want completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
